// File: rtl/fanin_merge_pkg.sv
// Shared constants, types and helpers for the round-robin fan-in merge.
// The optional accepted-beat counter is controlled by FANIN_MERGE_CNT_EN.
package fanin_merge_pkg;

    localparam int N_IN_MAX = 16;
    localparam int CNT_W    = 16;

    typedef logic [CNT_W-1:0] xfer_cnt_t;

    // Index width for n entries; a single bit is kept even when n <= 2.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fanin_rr_merge_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found scanning
// from ptr upward (mod N) wins. Priority pointer state lives in the parent.
module rr_arbiter
    import fanin_merge_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k is below 2N, so a single subtraction performs the wrap.
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (en && !any && req[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                gnt_idx          = pos[IW-1:0];
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fanin_rr_merge.sv
// N_IN valid/ready sources merged into one registered sink via round-robin.
// Define FANIN_MERGE_CNT_EN to add the saturating xfer_cnt beat counter.
module fanin_rr_merge
    import fanin_merge_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = idx_w(N_IN)
) (
    input  logic                     iccad_clk,
    input  logic                     iccad_rst_n,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_src,
    input  logic                     out_ready
`ifdef FANIN_MERGE_CNT_EN
    ,
    output logic [CNT_W-1:0]         xfer_cnt
`endif
);

    // Handshake: a beat moves on a rising edge where valid && ready are both
    // high; producers hold valid and data until then. in_ready is derived
    // from in_valid and output-register occupancy only, never from in_data.

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [N_IN-1:0]   gnt;
    logic              gnt_any;
    logic              can_load;
    logic [DATA_W-1:0] gnt_data;

    assign can_load = !out_valid || out_ready;

    // Reset gates the enable so no source sees ready while held in reset.
    rr_arbiter #(
        .N(N_IN)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .en      (can_load && iccad_rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign in_ready = gnt;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt[i])
                gnt_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            rr_ptr    <= (gnt_idx == IDX_W'(N_IN-1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FANIN_MERGE_CNT_EN
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n)
            xfer_cnt <= '0;
        else if (out_valid && out_ready && (xfer_cnt != '1))
            xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_fanin_rr_merge.sv
// Self-checking bench for fanin_rr_merge: directed scenarios plus randomized
// traffic against a queue-based round-robin reference model.
module tb_fanin_rr_merge;
    import fanin_merge_pkg::*;

    localparam int N_IN   = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    logic                   iccad_clk = 1'b0;
    logic                   iccad_rst_n;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [IDX_W-1:0]       out_src;
    logic                   out_ready;
`ifdef FANIN_MERGE_CNT_EN
    logic [CNT_W-1:0]       xfer_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                 m_ptr;
    logic               m_valid;
    logic [DATA_W-1:0]  m_data;
    logic [IDX_W-1:0]   m_src;
    int                 m_grant;
    int                 m_cnt;
    logic [N_IN-1:0]    exp_ready;
    logic [N_IN-1:0]    act_ready;
    logic               deliver;
    logic [IDX_W+DATA_W-1:0] deliver_beat;
    logic [IDX_W+DATA_W-1:0] exp_q[$];

    fanin_rr_merge #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W)
    ) dut (
        .iccad_clk   (iccad_clk),
        .iccad_rst_n (iccad_rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready)
`ifdef FANIN_MERGE_CNT_EN
        ,
        .xfer_cnt    (xfer_cnt)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 iccad_clk = ~iccad_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [DATA_W-1:0] get_data(input int i);
        return DATA_W'(in_data >> (i*DATA_W));
    endfunction

    task automatic set_data(input int i, input logic [DATA_W-1:0] d);
        logic [N_IN*DATA_W-1:0] mask;
        mask    = (N_IN*DATA_W)'({DATA_W{1'b1}}) << (i*DATA_W);
        in_data = (in_data & ~mask) | ((N_IN*DATA_W)'(d) << (i*DATA_W));
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = '0;
        m_grant = -1;
        m_cnt   = 0;
    endtask

    // Round-robin rule: first valid source at or after the pointer, when the
    // output register is free or draining this cycle.
    function automatic int model_grant();
        if (!iccad_rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < N_IN; k++) begin
            if (in_valid[IDX_W'((m_ptr + k) % N_IN)])
                return (m_ptr + k) % N_IN;
        end
        return -1;
    endfunction

    // Advance one clock: sample combinational outputs mid-low-phase, then
    // update the model at the rising edge; returns 1 time unit after it.
    task automatic tick();
        int g;
        if (iccad_clk) @(negedge iccad_clk);
        #1;
        g            = model_grant();
        exp_ready    = (g >= 0) ? (N_IN'(1) << g) : '0;
        act_ready    = in_ready;
        m_grant      = g;
        deliver      = out_valid && out_ready;
        deliver_beat = {out_src, out_data};
        @(posedge iccad_clk);
        if (m_valid && out_ready && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_src   = IDX_W'(g);
            m_data  = get_data(g);
            m_ptr   = (g + 1) % N_IN;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge iccad_clk);
        iccad_rst_n = 1'b0;
        in_valid    = '0;
        out_ready   = 1'b0;
        model_reset();
        @(negedge iccad_clk);
        iccad_rst_n = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DATA_W-1:0] exp_d;
        iccad_rst_n = 1'b0;
        in_valid    = '1;
        out_ready   = 1'b1;
        for (int i = 0; i < N_IN; i++) set_data(i, DATA_W'($urandom));
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b in_ready=%h, required 0/00", out_valid, in_ready);
        end
        @(posedge iccad_clk);
        #1;
        checks++;
        if ({out_valid, out_src, out_data, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_held: valid=%b src=%0d data=%h ready=%h, required all zero",
                     out_valid, out_src, out_data, in_ready);
        end
`ifdef FANIN_MERGE_CNT_EN
        checks++;
        if (xfer_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt: xfer_cnt=%h required 0000", xfer_cnt);
        end
`endif
        @(negedge iccad_clk);
        iccad_rst_n = 1'b1;
        // All sources valid: grants must sweep 0..7 and wrap to 0.
        for (int k = 0; k < 9; k++) begin
            exp_d = get_data(k % N_IN);
            tick();
            checks++;
            if (act_ready !== (N_IN'(1) << (k % N_IN))) begin
                errors++;
                $display("FAIL sweep_ready[%0d]: in_ready=%h required %h", k, act_ready, N_IN'(1) << (k % N_IN));
            end
            checks++;
            if (out_valid !== 1'b1 || out_src !== IDX_W'(k % N_IN) || out_data !== exp_d) begin
                errors++;
                $display("FAIL sweep_out[%0d]: valid=%b src=%0d data=%h required 1/%0d/%h",
                         k, out_valid, out_src, out_data, k % N_IN, exp_d);
            end
            set_data(k % N_IN, DATA_W'($urandom));
        end
    endtask

    task automatic test_sparse();
        logic [DATA_W-1:0] exp_d;
        int exp_s[3] = '{2, 5, 2};
        apply_reset();
        in_valid  = 8'b0010_0100;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_d = get_data(exp_s[k]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== IDX_W'(exp_s[k]) || out_data !== exp_d) begin
                errors++;
                $display("FAIL sparse[%0d]: valid=%b src=%0d data=%h required 1/%0d/%h",
                         k, out_valid, out_src, out_data, exp_s[k], exp_d);
            end
            set_data(exp_s[k], DATA_W'($urandom));
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_d;
        apply_reset();
        set_data(0, 8'hA5);
        in_valid  = 8'b0000_0001;
        out_ready = 1'b0;
        tick();
        in_valid = 8'b1111_1110;
        for (int i = 1; i < N_IN; i++) set_data(i, DATA_W'($urandom));
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (act_ready !== '0 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== '0) begin
                errors++;
                $display("FAIL backpressure[%0d]: ready=%h valid=%b data=%h src=%0d required 00/1/a5/0",
                         k, act_ready, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        exp_d = get_data(1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== exp_d || act_ready !== 8'h02) begin
            errors++;
            $display("FAIL bp_release: valid=%b src=%0d data=%h ready=%h required 1/1/%h/02",
                     out_valid, out_src, out_data, act_ready, exp_d);
        end
    endtask

    task automatic test_wrap();
        int exp_s[3] = '{7, 3, 4};
        logic [N_IN-1:0] vld[3] = '{8'b1000_0000, 8'b0000_1000, 8'b1111_1111};
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 8'b0100_0000;
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid = vld[k];
            tick();
            checks++;
            if (out_src !== IDX_W'(exp_s[k]) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap[%0d]: src=%0d valid=%b required %0d/1", k, out_src, out_valid, exp_s[k]);
            end
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        in_valid  = '1;
        out_ready = 1'b0;
        tick();
        #2;
        iccad_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            errors++;
            $display("FAIL midreset_async: out_valid=%b in_ready=%h required 0/00", out_valid, in_ready);
        end
        model_reset();
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge iccad_clk);
        iccad_rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
            errors++;
            $display("FAIL midreset_drop: valid=%b data=%h src=%0d required 0/00/0", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_random();
        int wait_cnt[N_IN];
        apply_reset();
        exp_q.delete();
        act_ready = '0;
        for (int i = 0; i < N_IN; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (act_ready[IDX_W'(i)]) begin
                    if ($urandom_range(0, 1) == 0) in_valid = in_valid & ~(N_IN'(1) << i);
                    else set_data(i, DATA_W'($urandom));
                end else if (!in_valid[IDX_W'(i)] && $urandom_range(0, 2) == 0) begin
                    set_data(i, DATA_W'($urandom));
                    in_valid    = in_valid | (N_IN'(1) << i);
                    wait_cnt[i] = 0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (act_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: in_ready=%h required %h", n, act_ready, exp_ready);
            end
            checks++;
            if ({out_valid, out_src, out_data} !== {m_valid, m_src, m_data}) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b src=%0d data=%h required %b/%0d/%h",
                         n, out_valid, out_src, out_data, m_valid, m_src, m_data);
            end
            if (deliver) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_sb[%0d]: delivered %h with nothing expected", n, deliver_beat);
                end else if (deliver_beat !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_sb[%0d]: delivered %h required %h", n, deliver_beat, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (m_grant >= 0) exp_q.push_back({IDX_W'(m_grant), m_data});
            if (act_ready != '0) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (act_ready[IDX_W'(i)]) wait_cnt[i] = 0;
                    else if (in_valid[IDX_W'(i)]) wait_cnt[i]++;
                    checks++;
                    if (wait_cnt[i] >= N_IN) begin
                        errors++;
                        $display("FAIL fairness[%0d]: source %0d waited %0d accepts, limit %0d",
                                 n, i, wait_cnt[i], N_IN - 1);
                    end
                end
            end
        end
`ifdef FANIN_MERGE_CNT_EN
        checks++;
        if (xfer_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL rand_cnt: xfer_cnt=%0d required %0d", xfer_cnt, m_cnt);
        end
`endif
    endtask

`ifdef FANIN_MERGE_CNT_EN
    task automatic test_saturation();
        apply_reset();
        in_valid  = '1;
        out_ready = 1'b1;
        for (int n = 0; n < 70000; n++) tick();
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat: xfer_cnt=%h required ffff", xfer_cnt);
        end
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_hold: xfer_cnt=%h required ffff", xfer_cnt);
        end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        in_data = '0;
        test_reset();
        test_sparse();
        test_backpressure();
        test_wrap();
        test_midreset();
        test_random();
`ifdef FANIN_MERGE_CNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fanin_rr_merge.md
Name: fanin_rr_merge

Overview:
- Merges N_IN independent valid/ready source streams into one sink stream. It is the converging counterpart of a single-driver high-fanout net: many producers feed one consumer.
- Uses a round-robin arbiter and a single registered output stage.
- Sits in the netlist-enhancer test designs in front of any shared single-load resource.
- Gives the buffering/sizing flow a realistic fan-in cone with sequential state.

Parameters:
- N_IN, 8, number of source ports (2..16).
- DATA_W, 8, payload width per source.
- IDX_W, $clog2(N_IN), width of the source index. Derived; do not override.

Ports:
- iccad_clk  input  1  sole clock, rising edge.
- iccad_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N_IN  per-source valid.
- in_data  input  N_IN*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_IN  per-source ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered payload.
- out_src  output  IDX_W  index of the source that supplied out_data.
- out_ready  input  1  sink accepts the beat.
- xfer_cnt  output  16  accepted-beat counter; present only with FANIN_MERGE_CNT_EN.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=0, xfer_cnt=0. in_ready is 0 while in reset.
- Handshake:
  - A beat transfers when valid&&ready are both high at a rising edge.
  - A source must hold valid and data stable until it is accepted (bench asserts this).
- Output stage:
  - can_load = !out_valid || out_ready.
- Arbitration (combinational):
  - When can_load=1, the grant goes to the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod N_IN.
  - in_ready = onehot(grant) when can_load=1 and any in_valid is high; otherwise 0.
  - in_ready may depend on in_valid. in_ready never depends on in_data.
- On accept of source g:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod N_IN; wrap from N_IN-1 to 0.
- On out_ready with no new accept: out_valid <= 0. out_data and out_src hold their last value.
- Simultaneous drain and load (out_valid=1, out_ready=1, a source granted): the old beat leaves and the new beat loads in the same edge. Full throughput is 1 beat/cycle.
- Back-pressure (out_valid=1, out_ready=0): all in_ready=0, register holds, rr_ptr holds.
- Latency: accept edge to out_valid high is 1 cycle. No combinational path from in_data to out_data.
- No valid inputs: rr_ptr holds and there is no grant.
- Fairness: any continuously valid source is granted within N_IN accepts.
- Reset mid-operation: a pending beat is dropped and all state returns to the reset values immediately.

Optional Feature:
- Macro: FANIN_MERGE_CNT_EN.
- Defined:
  - xfer_cnt port exists and increments on each out_valid&&out_ready.
  - It saturates at 16'hFFFF (no wrap).
  - It is cleared by reset only.
- Undefined: no xfer_cnt port or register. All other behaviour is identical.

Decomposition:
- Package fanin_merge_pkg:
  - N_IN_MAX=16.
  - CNT_W=16.
  - function idx_w(n) returning $clog2(n), min 1.
  - typedef logic [CNT_W-1:0] xfer_cnt_t.
- Sub-module rr_arbiter:
  - Parameters: N.
  - Inputs: req, ptr, en.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Purely combinational; rr_ptr state stays in fanin_rr_merge.

Test Plan:
1. Reset with all in_valid=8'hFF → out_valid=0, in_ready=0, xfer_cnt=0. After release with out_ready=1, grants are 0,1,…,7,0 on consecutive cycles, and out_src follows one cycle later.
2. in_valid=8'b0010_0100, rr_ptr=0, out_ready=1 → source 2 granted first (out_data=in_data[2]), then source 5, then source 2 again.
3. Back-pressure: hold out_ready=0 for 4 cycles with out_valid=1 and data 8'hA5 → in_ready=0, and out_data=8'hA5 and out_src stay stable. Raising out_ready → next beat loads on that same edge.
4. Only source 7 valid, rr_ptr=7 → grant 7, rr_ptr wraps to 0. Next request on source 3 → granted, rr_ptr=4.
5. Drop iccad_rst_n mid-stream while out_valid=1 → out_valid=0 asynchronously, before the next clock edge. The beat is not delivered after release.
6. With FANIN_MERGE_CNT_EN, 70000 back-to-back beats → xfer_cnt=16'hFFFF and stays there. Without the macro the design elaborates with no xfer_cnt port.
